soc_bus_fabric: RTL and testbench

SOC_BUS_FABRIC -- requirements
Module: soc_bus_fabric

---
 rtl/soc_bus_fabric.sv | 220 ++++++++++++++++++++++
 tb/tb_soc_bus_fabric.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: single-master bus fabric decoding one request at a time onto
// NUM_SLAVES address-mapped slave ports, with a registered one-cycle response.
// Optional slave timeout: define SOC_BUS_FABRIC_TIMEOUT_EN to abort an access
// that waits TIMEOUT_CYCLES cycles without s_ready; otherwise ACCESS waits forever.

module soc_bus_fabric #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'hFFFF0100, 32'hFFFF0000, 32'h00010000, 32'h00000000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
    {32'hFFFFFF00, 32'hFFFFFF00, 32'hFFFF0000, 32'hFFFF0000},
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                             clk,
  input  logic                             rst,
  // master side
  input  logic [ADDR_WIDTH-1:0]            m_addr,
  input  logic [DATA_WIDTH-1:0]            m_wdata,
  input  logic                             m_ren,
  input  logic                             m_wen,
  output logic [DATA_WIDTH-1:0]            m_rdata,
  output logic                             m_ready,
  output logic                             m_err,
  // slave side
  output logic [NUM_SLAVES-1:0]            s_sel,
  output logic [ADDR_WIDTH-1:0]            s_addr,
  output logic [DATA_WIDTH-1:0]            s_wdata,
  output logic                             s_ren,
  output logic                             s_wen,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]            s_ready,
  // error statistics
  output logic [7:0]                       err_count
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CNT_W = 8;

  // Parameter sanity check at elaboration.
  if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("soc_bus_fabric: NUM_SLAVES must be 1..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    rd_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    ready_q;
  logic                    err_q;
  logic [NUM_SLAVES-1:0]   sel_q;
  logic                    ren_q;
  logic                    wen_q;
  logic [CNT_W-1:0]        err_cnt_q;

  logic                    dec_hit;
  logic [IDX_W-1:0]        dec_idx;
  logic [NUM_SLAVES-1:0]   dec_sel;
  logic                    slv_ready;
  logic [DATA_WIDTH-1:0]   slv_rdata;
  logic [CNT_W-1:0]        err_cnt_inc;
  logic                    tmo_hit;

`ifdef SOC_BUS_FABRIC_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]        tmo_q;

  // Last permitted ACCESS cycle reached without a slave response.
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Address decode of the live request; lowest matching index wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    dec_sel = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (!dec_hit &&
          ((m_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
           SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        dec_hit    = 1'b1;
        dec_idx    = IDX_W'(i);
        dec_sel[i] = 1'b1;
      end
    end
  end

  // Ready/read-data mux for the slave selected by the latched index.
  always_comb begin
    slv_ready = 1'b0;
    slv_rdata = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (idx_q == IDX_W'(i)) begin
        slv_ready = s_ready[i];
        slv_rdata = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Saturating error counter increment.
  assign err_cnt_inc = (err_cnt_q == {CNT_W{1'b1}}) ? err_cnt_q : err_cnt_q + CNT_W'(1);

  // Transaction FSM with all master/slave outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rd_q      <= 1'b0;
      idx_q     <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      sel_q     <= '0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      err_cnt_q <= '0;
`ifdef SOC_BUS_FABRIC_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (m_ren || m_wen) begin
            addr_q  <= m_addr;
            wdata_q <= m_wdata;
            rd_q    <= m_ren;
            idx_q   <= dec_idx;
            if (dec_hit && !(m_ren && m_wen)) begin
              state_q <= ACCESS;
              sel_q   <= dec_sel;
              ren_q   <= m_ren;
              wen_q   <= m_wen;
`ifdef SOC_BUS_FABRIC_TIMEOUT_EN
              tmo_q   <= '0;
`endif
            end else begin
              // Unmapped address or conflicting read+write: no slave strobes.
              state_q   <= ERR;
              ready_q   <= 1'b1;
              err_q     <= 1'b1;
              err_cnt_q <= err_cnt_inc;
              if (m_ren) begin
                rdata_q <= ERR_DATA;
              end
            end
          end
        end

        ACCESS: begin
          if (slv_ready) begin
            if (rd_q) begin
              rdata_q <= slv_rdata;
            end
            sel_q   <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            ready_q <= 1'b1;
            state_q <= RESP;
          end else if (tmo_hit) begin
            sel_q     <= '0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            ready_q   <= 1'b1;
            err_q     <= 1'b1;
            err_cnt_q <= err_cnt_inc;
            state_q   <= ERR;
            if (rd_q) begin
              rdata_q <= ERR_DATA;
            end
          end
`ifdef SOC_BUS_FABRIC_TIMEOUT_EN
          else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end

        RESP, ERR: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          sel_q   <= '0;
          ren_q   <= 1'b0;
          wen_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_rdata   = rdata_q;
  assign m_ready   = ready_q;
  assign m_err     = err_q;
  assign s_sel     = sel_q;
  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign s_ren     = ren_q;
  assign s_wen     = wen_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Scoreboard bench for soc_bus_fabric: a driver issues directed and random
// requests and queues the expected response; a monitor checks slave strobes
// every cycle and pops/compares whenever m_ready is presented.

module tb_soc_bus_fabric;

  localparam int unsigned NS  = 4;
  localparam int unsigned DW  = 32;
  localparam int          TMO = 64;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  errc;
    int          cyc;
    int          strobes;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [31:0]      m_addr, m_wdata, m_rdata;
  logic             m_ren, m_wen, m_ready, m_err;
  logic [NS-1:0]    s_sel;
  logic [31:0]      s_addr, s_wdata;
  logic             s_ren, s_wen;
  logic [NS*DW-1:0] s_rdata;
  logic [NS-1:0]    s_ready;
  logic [7:0]       err_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Address map as given by the default parameters (slave 0 = LSB word).
  logic [31:0] base_a [NS] = '{32'h0000_0000, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_0100};
  logic [31:0] mask_a [NS] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_FF00};

  logic [DW-1:0] slave_data [NS];
  int            wait_cfg   [NS];
  int            wcnt       [NS];

  exp_t        sb[$];
  exp_t        mon_e;
  exp_t        tmo_e;
  logic [NS-1:0] cur_sel;
  logic        cur_ren, cur_wen;
  logic [31:0] cur_addr, cur_wdata;
  logic [31:0] model_rdata;
  int          model_err;
  int          strobe_cycles;
  int          lead;

  soc_bus_fabric dut (
    .clk       (clk),
    .rst       (rst),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_ren     (m_ren),
    .m_wen     (m_wen),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready),
    .m_err     (m_err),
    .s_sel     (s_sel),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_ren     (s_ren),
    .s_wen     (s_wen),
    .s_rdata   (s_rdata),
    .s_ready   (s_ready),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < int'(NS); i++) s_rdata[i*DW +: DW] = slave_data[i];
  end

  // Slave models: a selected slave answers after wait_cfg cycles; idle ones toggle noise.
  always @(negedge clk) begin
    for (int i = 0; i < int'(NS); i++) begin
      if (s_sel[i]) begin
        s_ready[i] = (wcnt[i] >= wait_cfg[i]);
        wcnt[i]    = wcnt[i] + 1;
      end else begin
        wcnt[i]    = 0;
        s_ready[i] = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < int'(NS); i++)
      if ((a & mask_a[i]) == base_a[i]) return i;
    return -1;
  endfunction

  // Drive a request now; lead = posedges until the DUT samples it.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic ren,
                       input logic wen, input int w, input logic [31:0] sdata, input int ld);
    int   idx;
    exp_t e;
    idx = decode(a);
    m_addr = a; m_wdata = d; m_ren = ren; m_wen = wen;
    if (idx < 0 || (ren && wen)) begin
      if (model_err < 255) model_err++;
      if (ren) model_rdata = ERR_DATA;
      e.err = 1'b1; e.cyc = cyc + ld; e.strobes = 0;
      cur_sel = '0; cur_ren = 1'b0; cur_wen = 1'b0;
    end else begin
      slave_data[idx] = sdata;
      wait_cfg[idx]   = w;
      if (ren) model_rdata = sdata;
      e.err = 1'b0; e.cyc = cyc + ld + 1 + w; e.strobes = 1 + w;
      cur_sel = '0; cur_sel[idx] = 1'b1;
      cur_ren = ren; cur_wen = wen; cur_addr = a; cur_wdata = d;
    end
    e.rdata = model_rdata;
    e.errc  = 8'(model_err);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1; m_ren = 1'b0; m_wen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    strobe_cycles = 0;
    model_rdata = '0; model_err = 0;
    cur_sel = '0; cur_ren = 1'b0; cur_wen = 1'b0;
    check("rst_m_ready",   32'(m_ready),   32'd0);
    check("rst_m_err",     32'(m_err),     32'd0);
    check("rst_s_sel",     32'(s_sel),     32'd0);
    check("rst_s_strobes", 32'({s_ren, s_wen}), 32'd0);
    check("rst_m_rdata",   m_rdata,        32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
  endtask

  // Wait (bounded) for the response; optionally drop the request once sampled.
  task automatic wait_resp(input int ld, input bit hold);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!hold && n >= ld && !m_ready) begin
        m_ren = 1'b0; m_wen = 1'b0; m_addr = $urandom; m_wdata = $urandom;
      end
    end while (!m_ready && n < 300);
    check("resp_seen", 32'(m_ready), 32'd1);
    if (!m_ready) do_reset();
  endtask

  task automatic idle1();
    m_ren = 1'b0; m_wen = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: strobe legality every cycle, scoreboard pop on every response.
  always @(negedge clk) begin
    if (s_sel != '0 || s_ren || s_wen) begin
      strobe_cycles++;
      check("s_sel",   32'(s_sel), 32'(cur_sel));
      check("s_ren",   32'(s_ren), 32'(cur_ren));
      check("s_wen",   32'(s_wen), 32'(cur_wen));
      check("s_addr",  s_addr,     cur_addr);
      check("s_wdata", s_wdata,    cur_wdata);
    end
    if (m_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_m_ready", 32'(m_ready), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("m_err",         32'(m_err),      32'(mon_e.err));
        check("m_rdata",       m_rdata,         mon_e.rdata);
        check("err_count",     32'(err_count),  32'(mon_e.errc));
        check("resp_cycle",    32'(cyc),        32'(mon_e.cyc));
        check("strobe_cycles", 32'(strobe_cycles), 32'(mon_e.strobes));
      end
      strobe_cycles = 0;
    end else if (m_err) begin
      check("m_err_without_ready", 32'(m_err), 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          sel, op, k;
    logic        ren, wen;

    rst = 1'b1; m_addr = '0; m_wdata = '0; m_ren = 1'b0; m_wen = 1'b0;
    for (int i = 0; i < int'(NS); i++) begin
      slave_data[i] = '0; wait_cfg[i] = 0; wcnt[i] = 0;
    end
    s_ready = '0;
    cur_addr = '0; cur_wdata = '0;
    strobe_cycles = 0;
    repeat (2) @(negedge clk);
    do_reset();

    // Zero-wait read of 0x00010004 (slave 1 in this map).
    issue(32'h0001_0004, 32'h0, 1'b1, 1'b0, 0, 32'h1234_5678, 1);
    wait_resp(1, 1'b0);
    idle1();

    // Write with three slave wait cycles: four strobe cycles, response in cycle 5.
    issue(32'hFFFF_0104, 32'h0000_00A5, 1'b0, 1'b1, 3, 32'h0, 1);
    wait_resp(1, 1'b0);
    idle1();

    // Unmapped read.
    issue(32'h8000_0000, 32'h0, 1'b1, 1'b0, 0, 32'h0, 1);
    wait_resp(1, 1'b0);
    idle1();

    // Back-to-back reads with the request held, then a read+write conflict.
    issue(32'h0000_0010, 32'h0, 1'b1, 1'b0, 0, $urandom, 1);
    wait_resp(1, 1'b1);
    issue(32'hFFFF_0020, 32'h0, 1'b1, 1'b0, 0, $urandom, 2);
    wait_resp(2, 1'b1);
    issue(32'h0000_0020, 32'h5555_AAAA, 1'b1, 1'b1, 0, $urandom, 2);
    wait_resp(2, 1'b1);
    idle1();

    // Randomized traffic.
    lead = 1;
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 4);
      if (sel < 4) a = base_a[sel] | ($urandom & ~mask_a[sel]);
      else         a = $urandom;
      op  = $urandom_range(0, 9);
      ren = (op < 5) || (op == 9);
      wen = (op >= 5);
      issue(a, $urandom, ren, wen, $urandom_range(0, 4), $urandom, lead);
      wait_resp(lead, 1'($urandom_range(0, 1)));
      k = $urandom_range(0, 2);
      if (k > 0) begin
        m_ren = 1'b0; m_wen = 1'b0;
        repeat (k) @(negedge clk);
        lead = 1;
      end else begin
        lead = 2;
      end
    end
    idle1();

    // Error counter saturation.
    lead = 1;
    for (int n = 0; n < 260; n++) begin
      ren = 1'($urandom_range(0, 1));
      issue(32'h8000_0000 | ($urandom & 32'h0FFF_FFFF), $urandom, ren, ~ren, 0, 32'h0, lead);
      wait_resp(lead, 1'b1);
      lead = 2;
    end
    idle1();

    // Slave 1 never ready.
`ifdef SOC_BUS_FABRIC_TIMEOUT_EN
    issue(32'h0001_0040, 32'h0, 1'b1, 1'b0, 100000, $urandom, 1);
    tmo_e = sb.pop_back();
    if (model_err < 255) model_err++;
    model_rdata   = ERR_DATA;
    tmo_e.err     = 1'b1;
    tmo_e.rdata   = ERR_DATA;
    tmo_e.errc    = 8'(model_err);
    tmo_e.cyc     = cyc + 1 + TMO;
    tmo_e.strobes = TMO;
    sb.push_back(tmo_e);
    wait_resp(1, 1'b0);
    idle1();
`else
    issue(32'h0001_0040, 32'h0, 1'b1, 1'b0, 100000, $urandom, 1);
    tmo_e = sb.pop_back();
    @(negedge clk);
    m_ren = 1'b0;
    repeat (199) @(negedge clk);
    check("still_waiting_sel",   32'(s_sel),   32'b0010);
    check("still_waiting_ren",   32'(s_ren),   32'd1);
    check("still_waiting_ready", 32'(m_ready), 32'd0);
    do_reset();
`endif

    // Reset in the middle of an ACCESS, then a normal read to slave 0.
    issue(32'h0000_0100, 32'h0, 1'b1, 1'b0, 10, $urandom, 1);
    @(negedge clk);
    m_ren = 1'b0;
    @(negedge clk);
    check("mid_access_sel", 32'(s_sel), 32'b0001);
    do_reset();
    issue(32'h0000_0200, 32'h0, 1'b1, 1'b0, 0, $urandom, 1);
    wait_resp(1, 1'b0);
    idle1();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
